// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the UART TX frame scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [5:0] HDR_MAGIC      = 6'b101101;

    localparam logic [1:0] SRC_GAME_STATE = 2'd0;
    localparam logic [1:0] SRC_GLOVES     = 2'd1;
    localparam logic [1:0] SRC_SCORE      = 2'd2;
    localparam logic [1:0] SRC_MOUSE      = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } uart_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
// ============================================================================
// Module      : uart_tx_scheduler_if
// Description : Source data and UART TX FIFO write-port bundle of the scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_scheduler_if #(
    parameter int N_SRC = 4
);
    logic                 tx_full;
    logic [N_SRC*8-1:0]   src_data;
    logic                 wr_uart;
    logic [7:0]           w_data;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  tx_full,
        input  src_data,
        output wr_uart,
        output w_data,
        output busy,
        output frame_done
    );

    modport slave (
        output tx_full,
        output src_data,
        input  wr_uart,
        input  w_data,
        input  busy,
        input  frame_done
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick of the first request at or
//               after a pointer; N must be a power of two.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [PTR_W-1:0] o_grant,
    output logic                  o_any_req
);

    logic [PTR_W-1:0] w_idx;

    // Scan offsets from the far end back toward i_ptr so the closest request wins;
    // the index wraps naturally because N == 2**PTR_W.
    always_comb begin
        o_grant   = '0;
        o_any_req = |i_req;
        w_idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = i_ptr + PTR_W'(k);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin scheduler sending changed/refreshed source bytes
//               to the UART TX FIFO as {header, payload} frames.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
    parameter int                N_SRC          = 4,
    parameter int                ID_W           = 2,
    parameter logic [7-ID_W:0]   HDR_MAGIC      = uart_pkg::HDR_MAGIC,
    parameter int                REFRESH_CYCLES = 65_000_000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_tx_scheduler_if.master  bus
);

    localparam int             c_cnt_w   = $clog2(REFRESH_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_CYCLES - 1);

    localparam logic [1:0] c_st_idle = uart_pkg::IDLE;
    localparam logic [1:0] c_st_hdr  = uart_pkg::HDR;
    localparam logic [1:0] c_st_pay  = uart_pkg::PAY;

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [7:0]         r_pay;
    logic               r_wr_uart;
    logic [7:0]         r_w_data;
    logic               r_frame_done;
    logic [c_cnt_w-1:0] r_cnt;

    logic [N_SRC-1:0]   w_pending;
    logic [ID_W-1:0]    w_grant;
    logic               w_any;
    logic               w_tick;
    logic               w_hdr_fire;
    logic               w_pay_fire;

    assign w_tick     = (r_cnt == c_cnt_max);
    assign w_hdr_fire = (r_state == c_st_hdr) && !bus.tx_full && !r_wr_uart;
    assign w_pay_fire = (r_state == c_st_pay) && !bus.tx_full && !r_wr_uart;

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Per-source shadow and sticky pending. In the clear cycle the comparison is
    // made against the byte being committed to shadow, so a source that moved on
    // after its grant re-arms and one that did not stays quiet.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        logic [7:0] r_shadow;
        logic       r_pend;
        logic [7:0] w_src;
        logic [7:0] w_ref;
        logic       w_clr;
        logic       w_set;

        assign w_src = bus.src_data[8*gi +: 8];
        assign w_clr = w_pay_fire && (r_id == ID_W'(gi));
        assign w_ref = w_clr ? r_pay : r_shadow;
        assign w_set = (w_src != w_ref) || w_tick;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_shadow <= '0;
                r_pend   <= 1'b1;
            end else begin
                if (w_clr) begin
                    r_shadow <= r_pay;
                end
                r_pend <= w_set | (r_pend & ~w_clr);
            end
        end

        assign w_pending[gi] = r_pend;
    end

    rr_arbiter #(
        .N     (N_SRC),
        .PTR_W (ID_W)
    ) u_arb (
        .i_req     (w_pending),
        .i_ptr     (r_rr_ptr),
        .o_grant   (w_grant),
        .o_any_req (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_pay        <= '0;
            r_wr_uart    <= 1'b0;
            r_w_data     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_uart    <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_pay    <= bus.src_data[{w_grant, 3'b000} +: 8];
                        r_id     <= w_grant;
                        r_rr_ptr <= w_grant + 1'b1;
                        r_state  <= c_st_hdr;
                    end
                end
                c_st_hdr: begin
                    if (w_hdr_fire) begin
                        r_wr_uart <= 1'b1;
                        r_w_data  <= {HDR_MAGIC, r_id};
                        r_state   <= c_st_pay;
                    end
                end
                c_st_pay: begin
                    if (w_pay_fire) begin
                        r_wr_uart    <= 1'b1;
                        r_w_data     <= r_pay;
                        r_frame_done <= 1'b1;
                        r_state      <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.wr_uart    = r_wr_uart;
    assign bus.w_data     = r_w_data;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = (r_state != c_st_idle);

endmodule

`default_nettype wire
